// File: rtl/byte_serializer_if.sv
// byte_serializer_if: bus between a word producer and byte_serializer.
//   i_din / i_din_valid / o_din_ready : word write handshake
//   i_align                           : word-boundary strobe from the clock generator
//   i_clr_status                      : clears sticky status bits
//   o_dout / o_dout_valid             : serial bit and "carries data" flag
//   o_word_start                      : serial bit is bit 0 of a word
//   o_fifo_level                      : words queued
//   o_underrun / o_misalign           : sticky status
// Signal prefixes are from the serializer's point of view.
interface byte_serializer_if #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH + 1);

   logic [WIDTH-1:0] i_din;
   logic             i_din_valid;
   logic             o_din_ready;
   logic             i_align;
   logic             i_clr_status;
   logic             o_dout;
   logic             o_dout_valid;
   logic             o_word_start;
   logic [LW-1:0]    o_fifo_level;
   logic             o_underrun;
   logic             o_misalign;

   modport slave (
      input  i_din, i_din_valid, i_align, i_clr_status,
      output o_din_ready, o_dout, o_dout_valid, o_word_start,
             o_fifo_level, o_underrun, o_misalign
   );

   modport master (
      output i_din, i_din_valid, i_align, i_clr_status,
      input  o_din_ready, o_dout, o_dout_valid, o_word_start,
             o_fifo_level, o_underrun, o_misalign
   );
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: parallel-to-serial output stage on the bit clock.
// Words enter a DEPTH-deep FIFO through a valid/ready handshake and leave
// LSB first, one bit per i_clkin cycle. Word boundaries are self-timed
// (every WIDTH cycles) or forced by i_align. With nothing queued the idle
// word is shifted out; underrun and truncation are flagged sticky.
// Ports:
//   i_clkin : bit clock, rising edge
//   i_rst   : asynchronous active-high reset
//   bus     : byte_serializer_if slave modport (handshake, serial out, status)
module byte_serializer #(
   parameter int               WIDTH     = 8,
   parameter int               DEPTH     = 4,
   parameter logic [WIDTH-1:0] IDLE_WORD = '0
) (
   input logic                 i_clkin,
   input logic                 i_rst,
   byte_serializer_if.slave    bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam int BW = $clog2(WIDTH);
   localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wptr;
   logic [AW-1:0]    r_rptr;
   logic [LW-1:0]    r_level;
   logic [BW-1:0]    r_bcnt;
   logic [WIDTH-1:0] r_shreg;
   logic             r_dout_valid;
   logic             r_word_start;
   logic             r_underrun;
   logic             r_misalign;

   logic w_ready;
   logic w_wr;
   logic w_load;
   logic w_pop;
   logic w_set_underrun;
   logic w_set_misalign;

   // Ready is held low during reset so nothing is accepted while state is cleared.
   assign w_ready = ~i_rst & (r_level < LW'(DEPTH));
   assign w_wr    = bus.i_din_valid & w_ready;
   assign w_load  = (r_bcnt == BCNT_LAST) | bus.i_align;
   // Pop decision uses the pre-edge level, so a word written on a load edge
   // into an empty FIFO waits for the following load edge.
   assign w_pop   = w_load & (r_level != '0);

   assign w_set_underrun = w_load & ~w_pop & r_dout_valid;
   // ALIGN on the natural last bit is an ordinary load, not a truncation.
   assign w_set_misalign = bus.i_align & (r_bcnt != BCNT_LAST) & r_dout_valid;

   // FIFO storage needs no reset; validity is carried by the pointers/level.
   always_ff @(posedge i_clkin) begin
      if (w_wr) r_mem[r_wptr] <= bus.i_din;
   end

   always_ff @(posedge i_clkin or posedge i_rst) begin
      if (i_rst) begin
         r_wptr       <= '0;
         r_rptr       <= '0;
         r_level      <= '0;
         r_bcnt       <= BCNT_LAST;
         r_shreg      <= IDLE_WORD;
         r_dout_valid <= 1'b0;
         r_word_start <= 1'b0;
         r_underrun   <= 1'b0;
         r_misalign   <= 1'b0;
      end else begin
         if (w_wr)  r_wptr <= r_wptr + 1'b1;
         if (w_pop) r_rptr <= r_rptr + 1'b1;

         case ({w_wr, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase

         r_word_start <= w_load;

         if (w_load) begin
            r_bcnt       <= '0;
            r_shreg      <= w_pop ? r_mem[r_rptr] : IDLE_WORD;
            r_dout_valid <= w_pop;
         end else begin
            r_bcnt  <= r_bcnt + 1'b1;
            r_shreg <= {1'b0, r_shreg[WIDTH-1:1]};
         end

         // Set has priority over clear so no event is lost to a coincident clear.
         if (w_set_underrun)        r_underrun <= 1'b1;
         else if (bus.i_clr_status) r_underrun <= 1'b0;

         if (w_set_misalign)        r_misalign <= 1'b1;
         else if (bus.i_clr_status) r_misalign <= 1'b0;
      end
   end

   assign bus.o_din_ready  = w_ready;
   assign bus.o_dout       = r_shreg[0];
   assign bus.o_dout_valid = r_dout_valid;
   assign bus.o_word_start = r_word_start;
   assign bus.o_fifo_level = r_level;
   assign bus.o_underrun   = r_underrun;
   assign bus.o_misalign   = r_misalign;
endmodule
